// File: rtl/nexus_work_loader.sv
// Work-frame loader: assembles 56-word frames into a shadow buffer, then commits
// them to the hash core's work/nonce registers and pulses the core's reset.
module nexus_work_loader #(
    parameter int RSTCYCLES  = 2,
    parameter int FRAMEWORDS = 56
) (
    input  logic                           clk,
    input  logic                           nHashRst,
    input  logic [31:0]                    WordIn,
    input  logic                           WordValid,
    input  logic                           WordFirst,
    output logic                           WordReady,
    output logic [32*(FRAMEWORDS-2)-1:0]   WorkPkt,
    output logic [63:0]                    InNonce,
    output logic                           nCoreRst,
    output logic [7:0]                     WorkId,
    output logic                           FrameErr
);

    localparam int SHW  = 32 * FRAMEWORDS;
    localparam int PKTW = SHW - 64;
    localparam logic [5:0] LAST_IDX = 6'(FRAMEWORDS - 1);
    localparam logic [3:0] HOLD_LEN = 4'(RSTCYCLES);

    typedef enum logic {RX_IDLE, RX_LOAD} rx_state_t;

    rx_state_t         state_q;
    logic [5:0]        cnt_q;
    logic [SHW-1:0]    shadow_q;
    logic [PKTW-1:0]   work_pkt_q;
    logic [63:0]       in_nonce_q;
    logic [7:0]        work_id_q;
    logic              frame_err_q;
    logic              commit_q;
    logic              core_rst_n_q;
    logic [3:0]        hold_q;

    logic              accept;
    logic              wr_en;
    logic [5:0]        wr_idx;
    logic [7:0]        work_id_d;
    logic [3:0]        hold_d;

    // The core is only held off while a commit is in flight; before the first
    // commit nCoreRst is low but words are still accepted.
    assign WordReady = nHashRst & ~commit_q & (hold_q == 4'd0);
    assign accept    = WordValid & WordReady;
    assign wr_en     = accept & (WordFirst | (state_q == RX_LOAD));
    assign wr_idx    = WordFirst ? 6'd0 : cnt_q;
    assign work_id_d = work_id_q + 8'd1;
    assign hold_d    = hold_q - 4'd1;

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            state_q      <= RX_IDLE;
            cnt_q        <= 6'd0;
            shadow_q     <= '0;
            work_pkt_q   <= '0;
            in_nonce_q   <= '0;
            work_id_q    <= 8'd0;
            frame_err_q  <= 1'b0;
            commit_q     <= 1'b0;
            core_rst_n_q <= 1'b0;
            hold_q       <= 4'd0;
        end else begin
            frame_err_q <= 1'b0;
            commit_q    <= 1'b0;

            if (wr_en) begin
                shadow_q[32*wr_idx +: 32] <= WordIn;
            end

            if (accept) begin
                case (state_q)
                    RX_IDLE: begin
                        if (WordFirst) begin
                            cnt_q   <= 6'd1;
                            state_q <= RX_LOAD;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    RX_LOAD: begin
                        if (WordFirst) begin
                            frame_err_q <= 1'b1;
                            cnt_q       <= 6'd1;
                        end else if (cnt_q == LAST_IDX) begin
                            cnt_q    <= 6'd0;
                            state_q  <= RX_IDLE;
                            commit_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end

            // Word 55 lands in the shadow on the accept edge, so the copy waits one cycle.
            if (commit_q) begin
                work_pkt_q   <= shadow_q[PKTW-1:0];
                in_nonce_q   <= shadow_q[SHW-1:PKTW];
                work_id_q    <= work_id_d;
                core_rst_n_q <= 1'b0;
                hold_q       <= HOLD_LEN;
            end else if (hold_q != 4'd0) begin
                hold_q <= hold_d;
                if (hold_q == 4'd1) begin
                    core_rst_n_q <= 1'b1;
                end
            end
        end
    end

    assign WorkPkt  = work_pkt_q;
    assign InNonce  = in_nonce_q;
    assign WorkId   = work_id_q;
    assign FrameErr = frame_err_q;
    assign nCoreRst = core_rst_n_q;

endmodule

// File: tb/tb_nexus_work_loader.sv
// Directed bench for nexus_work_loader: frame commit, hold timing, framing
// errors, WorkId wrap and mid-frame reset.
module tb_nexus_work_loader;

    logic          clk;
    logic          nHashRst;
    logic [31:0]   WordIn;
    logic          WordValid;
    logic          WordFirst;
    logic          WordReady;
    logic [1727:0] WorkPkt;
    logic [63:0]   InNonce;
    logic          nCoreRst;
    logic [7:0]    WorkId;
    logic          FrameErr;

    int n_cmp;
    int n_err;
    int ferr_cnt;
    int ferr_base;
    logic [7:0]  exp_id;
    logic [31:0] last_pkt0;
    logic [63:0] last_nonce;

    nexus_work_loader #(.RSTCYCLES(2)) dut (
        .clk       (clk),
        .nHashRst  (nHashRst),
        .WordIn    (WordIn),
        .WordValid (WordValid),
        .WordFirst (WordFirst),
        .WordReady (WordReady),
        .WorkPkt   (WorkPkt),
        .InNonce   (InNonce),
        .nCoreRst  (nCoreRst),
        .WorkId    (WorkId),
        .FrameErr  (FrameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (FrameErr === 1'b1) ferr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; holds the word across exactly one rising edge.
    task automatic send_word(input logic [31:0] d, input logic f);
        int n;
        n = 0;
        while (WordReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (WordReady !== 1'b1) check_eq("ready_timeout", 64'(WordReady), 64'd1);
        WordIn    = d;
        WordFirst = f;
        WordValid = 1'b1;
        @(negedge clk);
        WordValid = 1'b0;
        WordFirst = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) send_word(base + 32'(k), (k == 0));
    endtask

    // Entered at the negedge right after word 55 was accepted.
    task automatic check_commit(input logic [31:0] base, input logic prev_nrst);
        logic [63:0] nonce;
        nonce = {base + 32'd55, base + 32'd54};
        exp_id = exp_id + 8'd1;
        check_eq("c1_ready", 64'(WordReady), 64'd0);
        check_eq("c1_nrst", 64'(nCoreRst), 64'(prev_nrst));
        check_eq("c1_pkt_hold", 64'(WorkPkt[31:0]), 64'(last_pkt0));
        @(negedge clk);
        check_eq("c2_pkt0", 64'(WorkPkt[31:0]), 64'(base));
        check_eq("c2_pkt53", 64'(WorkPkt[1727:1696]), 64'(base + 32'd53));
        check_eq("c2_nonce", InNonce, nonce);
        check_eq("c2_id", 64'(WorkId), 64'(exp_id));
        check_eq("c2_nrst", 64'(nCoreRst), 64'd0);
        check_eq("c2_ready", 64'(WordReady), 64'd0);
        @(negedge clk);
        check_eq("c3_nrst", 64'(nCoreRst), 64'd0);
        check_eq("c3_ready", 64'(WordReady), 64'd0);
        @(negedge clk);
        check_eq("c4_nrst", 64'(nCoreRst), 64'd1);
        check_eq("c4_ready", 64'(WordReady), 64'd1);
        last_pkt0  = base;
        last_nonce = nonce;
        $display("commit base=%h id=%0d nonce=%h", base, WorkId, InNonce);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ferr_cnt = 0;
        exp_id = 8'd0; last_pkt0 = 32'd0; last_nonce = 64'd0;
        nHashRst = 1'b0; WordIn = 32'd0; WordValid = 1'b0; WordFirst = 1'b0;

        // Reset state
        #2;
        check_eq("rst_pkt_any", 64'(|WorkPkt), 64'd0);
        check_eq("rst_nonce", InNonce, 64'd0);
        check_eq("rst_nrst", 64'(nCoreRst), 64'd0);
        check_eq("rst_ready", 64'(WordReady), 64'd0);
        check_eq("rst_id", 64'(WorkId), 64'd0);
        check_eq("rst_ferr", 64'(FrameErr), 64'd0);
        @(negedge clk); @(negedge clk);
        nHashRst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(WordReady), 64'd1);
        check_eq("post_rst_nrst", 64'(nCoreRst), 64'd0);

        // First frame
        send_words(32'h1000_0000, 56);
        check_commit(32'h1000_0000, 1'b0);

        // Second frame: committed outputs untouched while loading
        send_words(32'h2000_0000, 30);
        check_eq("load_pkt_stable", 64'(WorkPkt[31:0]), 64'h1000_0000);
        check_eq("load_nonce_stable", InNonce, last_nonce);
        for (int k = 30; k < 56; k++) send_word(32'h2000_0000 + 32'(k), 1'b0);
        check_commit(32'h2000_0000, 1'b1);

        // Stray non-first word while idle
        send_word(32'hDEAD_BEEF, 1'b0);
        check_eq("idle_ferr", 64'(FrameErr), 64'd1);
        @(negedge clk);
        check_eq("idle_ferr_clr", 64'(FrameErr), 64'd0);
        check_eq("idle_id", 64'(WorkId), 64'(exp_id));
        check_eq("idle_nonce", InNonce, last_nonce);
        check_eq("idle_nrst", 64'(nCoreRst), 64'd1);

        // Restart mid-frame
        ferr_base = ferr_cnt;
        send_words(32'h3000_0000, 10);
        send_word(32'h4000_0000, 1'b1);
        check_eq("restart_ferr", 64'(FrameErr), 64'd1);
        for (int k = 1; k < 56; k++) send_word(32'h4000_0000 + 32'(k), 1'b0);
        check_commit(32'h4000_0000, 1'b1);
        check_eq("restart_w9", 64'(WorkPkt[319:288]), 64'h4000_0009);
        check_eq("restart_pulses", 64'(ferr_cnt - ferr_base), 64'd1);

        // Reset after word 30
        send_words(32'h6000_0000, 31);
        nHashRst = 1'b0;
        #1;
        exp_id = 8'd0; last_pkt0 = 32'd0;
        check_eq("mid_rst_pkt_any", 64'(|WorkPkt), 64'd0);
        check_eq("mid_rst_nonce", InNonce, 64'd0);
        check_eq("mid_rst_nrst", 64'(nCoreRst), 64'd0);
        check_eq("mid_rst_ready", 64'(WordReady), 64'd0);
        check_eq("mid_rst_id", 64'(WorkId), 64'd0);
        check_eq("mid_rst_ferr", 64'(FrameErr), 64'd0);
        @(negedge clk);
        nHashRst = 1'b1;
        #1;
        check_eq("mid_rel_ready", 64'(WordReady), 64'd1);
        @(negedge clk);
        send_words(32'h5000_0000, 56);
        check_commit(32'h5000_0000, 1'b0);

        // 255 more frames: 256 commits since reset, WorkId wraps
        ferr_base = ferr_cnt;
        for (int f = 1; f < 256; f++) begin
            send_words({8'(f), 24'h00_0000}, 56);
            check_commit({8'(f), 24'h00_0000}, 1'b1);
        end
        check_eq("wrap_id", 64'(WorkId), 64'd0);
        check_eq("wrap_no_ferr", 64'(ferr_cnt - ferr_base), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
